// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter: two-port RAM16K arbiter, round-robin with MAX_BURST limit, fixed port-1 priority under RAM_ARB_FIXED_PRIO_EN
module ram16k_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);
  logic gnt0, gnt1, load_q, rd_b, port_b, rv0_q, rv1_q;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign gnt1 = p1_req;
  assign gnt0 = p0_req & ~p1_req;
`else
  logic ptr, last, pick1;
  logic [3:0] burst;
  always_comb begin
    pick1 = (burst >= 4'(MAX_BURST)) ? ~last : ptr;
    gnt1  = p1_req & (~p0_req | pick1);
    gnt0  = p0_req & ~gnt1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= 1'b0;
      last  <= 1'b0;
      burst <= '0;
    end else begin
      if (gnt0 | gnt1) begin
        ptr  <= gnt0;
        last <= gnt1;
      end
      burst <= (p0_req & p1_req) ? ((gnt1 == last) ? burst + 4'd1 : 4'd1) : 4'd0;
    end
  end
`endif
  assign p0_ack    = gnt0 & ~reset;
  assign p1_ack    = gnt1 & ~reset;
  assign ram_load  = load_q & ~reset;
  assign p0_rvalid = rv0_q & ~reset;
  assign p1_rvalid = rv1_q & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_address <= '0;
      ram_in      <= '0;
      load_q      <= 1'b0;
      rd_b        <= 1'b0;
      port_b      <= 1'b0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      load_q <= gnt0 ? p0_we : gnt1 & p1_we;
      rd_b   <= gnt0 ? ~p0_we : gnt1 & ~p1_we;
      if (gnt0 | gnt1) begin
        ram_address <= gnt1 ? p1_addr : p0_addr;
        ram_in      <= gnt1 ? p1_wdata : p0_wdata;
        port_b      <= gnt1;
      end
      rv0_q <= rd_b & ~port_b;
      rv1_q <= rd_b & port_b;
      if (rd_b & ~port_b) p0_rdata <= ram_out;
      if (rd_b & port_b) p1_rdata <= ram_out;
    end
  end
endmodule

// File: tb/tb_ram16k_arbiter.sv
// tb_ram16k_arbiter: scoreboard bench for ram16k_arbiter with a RAM16K model
module tb_ram16k_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [13:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic p0_ack, p0_rvalid, p1_ack, p1_rvalid, ram_load;
  logic [15:0] p0_rdata, p1_rdata, ram_in, ram_out;
  logic [13:0] ram_address;
  logic [15:0] mem [16384];
  logic [15:0] ref_mem [16384];
  typedef struct {int c; logic [15:0] d;} exp_t;
  typedef struct {int c; bit p;} g_t;
  exp_t q0[$], q1[$];
  g_t glog[$];
  int cyc = 0, total = 0, passed = 0;
  logic pend_w = 0;
  logic [13:0] pw_a;
  logic [15:0] pw_d;
  ram16k_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h want=%h cycle=%0d", tag, got, exp, cyc);
    else passed++;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (pend_w) begin
      if (!reset) ref_mem[pw_a] = pw_d;
      pend_w = 0;
    end
    if (reset) begin
      q0.delete();
      q1.delete();
    end
    if (p0_rvalid) begin
      if (q0.size() == 0) check("p0_rvalid_extra", 1, 0);
      else begin
        e = q0.pop_front();
        check("p0_rdata", p0_rdata, e.d);
        check("p0_latency", cyc, e.c);
      end
    end else if (q0.size() != 0 && q0[0].c <= cyc) begin
      check("p0_rvalid_miss", 0, 1);
      void'(q0.pop_front());
    end
    if (p1_rvalid) begin
      if (q1.size() == 0) check("p1_rvalid_extra", 1, 0);
      else begin
        e = q1.pop_front();
        check("p1_rdata", p1_rdata, e.d);
        check("p1_latency", cyc, e.c);
      end
    end else if (q1.size() != 0 && q1[0].c <= cyc) begin
      check("p1_rvalid_miss", 0, 1);
      void'(q1.pop_front());
    end
    if (p0_ack && p1_ack) check("dual_ack", 1, 0);
    if (p0_ack) begin
      glog.push_back('{cyc, 1'b0});
      if (p0_we) begin pend_w = 1; pw_a = p0_addr; pw_d = p0_wdata; end
      else q0.push_back('{cyc + 2, ref_mem[p0_addr]});
    end
    if (p1_ack) begin
      glog.push_back('{cyc, 1'b1});
      if (p1_we) begin pend_w = 1; pw_a = p1_addr; pw_d = p1_wdata; end
      else q1.push_back('{cyc + 2, ref_mem[p1_addr]});
    end
  end
  task automatic access(input int p, input logic we, input logic [13:0] a, input logic [15:0] d);
    int n = 0;
    if (p == 0) begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; end
    else begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; end
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 0 ? p0_ack : p1_ack) && n < 50);
    if (n >= 50) check("ack_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (p == 0) p0_req = 0;
    else p1_req = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", q0.size() + q1.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int t0, join_c, p0c, last1, n1;
    for (int i = 0; i < 16384; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_load", ram_load, 0);
    check("rst_acks", {p0_ack, p1_ack}, 0);
    check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    check("rst_addr", ram_address, 0);
    check("rst_in", ram_in, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_load", ram_load, 0);
    end
    @(posedge clk);
    #1;
    access(0, 1, 14'h0010, 16'hBEEF);
    reset = 1;
    @(negedge clk);
    check("rst_mid_load", ram_load, 0);
    @(posedge clk);
    #1;
    reset = 0;
    access(0, 0, 14'h0010, 16'h0);
    drain();
    check("rst_write_dropped", p0_rdata == 16'hBEEF, 0);
    access(0, 1, 14'h3FFF, 16'hA5A5);
    access(0, 0, 14'h3FFF, 16'h0);
    drain();
    check("p0_a5a5", p0_rdata, 16'hA5A5);
    access(1, 1, 14'h0001, 16'h1111);
    access(1, 1, 14'h0002, 16'h2222);
    glog.delete();
    fork
      repeat (6) access(0, 0, 14'h0001, 16'h0);
      repeat (6) access(1, 0, 14'h0002, 16'h0);
    join
    drain();
    check("rr_count", glog.size(), 12);
    for (int i = 1; i < glog.size(); i++) check("rr_alternate", glog[i].p != glog[i-1].p, 1);
    check("rr_p0_data", p0_rdata, 16'h1111);
    check("rr_p1_data", p1_rdata, 16'h2222);
    fork
      access(1, 1, 14'h0100, 16'h1234);
      begin
        @(posedge clk);
        #1;
        access(0, 0, 14'h0100, 16'h0);
      end
    join
    drain();
    check("raw", p0_rdata, 16'h1234);
    glog.delete();
    t0 = cyc;
    join_c = 0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    fork
      for (int i = 0; i < 20; i++) access(1, 1, 14'h0200 + 14'(i), 16'h5000 + 16'(i));
      access(0, 0, 14'h0200, 16'h0);
    join
    drain();
    p0c = -1;
    last1 = -1;
    foreach (glog[i]) if (glog[i].p) last1 = glog[i].c; else p0c = glog[i].c;
    check("fixed_p0_after_p1", p0c > last1, 1);
`else
    fork
      for (int i = 0; i < 10; i++) access(1, 1, 14'h0200 + 14'(i), 16'h5000 + 16'(i));
      begin
        repeat (6) @(posedge clk);
        #1;
        join_c = cyc;
        access(0, 0, 14'h0200, 16'h0);
      end
    join
    drain();
    p0c = -1;
    n1 = 0;
    foreach (glog[i]) begin
      if (glog[i].p && glog[i].c >= t0 && glog[i].c < t0 + 6) n1++;
      if (!glog[i].p) p0c = glog[i].c;
    end
    check("burst_p1_solo", n1, 6);
    check("burst_p0_join", (p0c >= join_c) && (p0c - join_c <= 1), 1);
    check("burst_p0_data", p0_rdata, 16'h5000);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
